// File: rtl/psum_pkg.sv
// Shared constants and helpers for the partial-sum adder tree.
// Holds default widths and a constant clog2 used for tree depth.
package psum_pkg;

   localparam int DATA_W_DEF      = 25;
   localparam int APPROX_BITS_DEF = 6;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/psum_add_lo.sv
// Two-operand adder with an optional approximate low part.
// Ports: a, b (signed W), approx_en (mode), sum (signed W, no wrap expected).
module psum_add_lo
   import psum_pkg::*;
#(
   parameter int W = 27,
   parameter int K = 6
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic                approx_en,
   output logic signed [W-1:0] sum
);

   generate
      if (K == 0) begin : g_exact
         logic unused_mode;
         assign unused_mode = approx_en;
         assign sum = a + b;
      end else begin : g_approx
         logic [K-1:0]   lo;
         logic [W-K-1:0] hi;
         logic           cin;

         // Low bits are OR-ed; the only carry into the exact upper part
         // is the AND of the two top low bits.
         always_comb begin
            cin = a[K-1] & b[K-1];
            lo  = a[K-1:0] | b[K-1:0];
            hi  = a[W-1:K] + b[W-1:K] + {{(W-K-1){1'b0}}, cin};
         end

         assign sum = approx_en ? {hi, lo} : a + b;
      end
   endgenerate

endmodule

// File: rtl/psum_add_tree.sv
// Pipelined PE partial-sum reduction tree with FIFO accumulate and saturation.
// Ports: clk, rst, en, in_valid, pe_data, fifo_data, acc_first, approx_en,
//        clr_sticky in; out_valid, out, sat, sat_sticky out.
module psum_add_tree
   import psum_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int NUM_PE      = 4,
   parameter int APPROX_BITS = APPROX_BITS_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            in_valid,
   input  logic signed [NUM_PE*DATA_W-1:0] pe_data,
   input  logic signed [DATA_W-1:0]        fifo_data,
   input  logic                            acc_first,
   input  logic                            approx_en,
   input  logic                            clr_sticky,
   output logic                            out_valid,
   output logic signed [DATA_W-1:0]        out,
   output logic                            sat,
   output logic                            sat_sticky
);

   localparam int LEVELS = clog2(NUM_PE);
   localparam int NP2    = 1 << LEVELS;
   localparam int ACC_W  = DATA_W + LEVELS + 1;

   localparam logic signed [ACC_W-1:0] MAXV =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] MAXO = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MINO = {1'b1, {(DATA_W-1){1'b0}}};

   // Nodes are kept at full accumulate width; sign extension makes the
   // approximate and exact results identical to per-level growth.
   logic signed [ACC_W-1:0]  lane [NP2];
   logic signed [ACC_W-1:0]  nsum [NP2-1];
   logic signed [ACC_W-1:0]  nreg [NP2-1];
   logic                     v_q  [LEVELS];
   logic                     am_q [LEVELS];
   logic                     af_q [LEVELS];
   logic signed [DATA_W-1:0] fd_q [LEVELS];

   logic signed [ACC_W-1:0]  fifo_ext;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [DATA_W-1:0] res;
   logic                     res_sat;

   for (genvar i = 0; i < NP2; i++) begin : g_lane
      if (i < NUM_PE) begin : g_pe
         assign lane[i] = ACC_W'($signed(pe_data[i*DATA_W +: DATA_W]));
      end else begin : g_pad
         assign lane[i] = '0;
      end
   end

   // Level l results live at nreg[OFF + j]; level l-1 feeds level l.
   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int N   = NP2 >> l;
      localparam int OFF = NP2 - (NP2 >> (l - 1));
      for (genvar j = 0; j < N; j++) begin : g_node
         logic signed [ACC_W-1:0] a;
         logic signed [ACC_W-1:0] b;
         logic                    m;
         if (l == 1) begin : g_in
            assign a = lane[2*j];
            assign b = lane[2*j+1];
            assign m = approx_en;
         end else begin : g_in
            localparam int P = NP2 - (NP2 >> (l - 2));
            assign a = nreg[P+2*j];
            assign b = nreg[P+2*j+1];
            assign m = am_q[l-2];
         end
         psum_add_lo #(.W(ACC_W), .K(APPROX_BITS)) u_add (
            .a         (a),
            .b         (b),
            .approx_en (m),
            .sum       (nsum[OFF+j])
         );
      end
   end

   assign fifo_ext = af_q[LEVELS-1] ? '0 : ACC_W'(fd_q[LEVELS-1]);

   psum_add_lo #(.W(ACC_W), .K(APPROX_BITS)) u_acc (
      .a         (nreg[NP2-2]),
      .b         (fifo_ext),
      .approx_en (am_q[LEVELS-1]),
      .sum       (acc_sum)
   );

   always_comb begin
      res     = acc_sum[DATA_W-1:0];
      res_sat = 1'b0;
      if (acc_sum > MAXV) begin
         res     = MAXO;
         res_sat = 1'b1;
      end else if (acc_sum < MINV) begin
         res     = MINO;
         res_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NP2 - 1; k++) nreg[k] <= '0;
         for (int l = 0; l < LEVELS; l++) begin
            v_q[l]  <= 1'b0;
            am_q[l] <= 1'b0;
            af_q[l] <= 1'b0;
            fd_q[l] <= '0;
         end
         out_valid  <= 1'b0;
         out        <= '0;
         sat        <= 1'b0;
         sat_sticky <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < NP2 - 1; k++) nreg[k] <= nsum[k];
         v_q[0]  <= in_valid;
         am_q[0] <= approx_en;
         af_q[0] <= acc_first;
         fd_q[0] <= fifo_data;
         for (int l = 1; l < LEVELS; l++) begin
            v_q[l]  <= v_q[l-1];
            am_q[l] <= am_q[l-1];
            af_q[l] <= af_q[l-1];
            fd_q[l] <= fd_q[l-1];
         end
         out_valid <= v_q[LEVELS-1];
         if (v_q[LEVELS-1]) begin
            out <= res;
            sat <= res_sat;
         end
         // Set has priority over a same-cycle clear.
         sat_sticky <= (v_q[LEVELS-1] & res_sat) |
                       (sat_sticky & ~clr_sticky);
      end else begin
         sat_sticky <= sat_sticky & ~clr_sticky;
      end
   end

endmodule

// File: tb/tb_psum_add_tree.sv
// Bench for psum_add_tree: directed steps with a queue scoreboard.
// A second instance with NUM_PE=3 checks zero padding of the last lane.
module tb_psum_add_tree;

   localparam int DW = 25;
   localparam int NP = 4;
   localparam int AB = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst;
   logic                     en;
   logic                     in_valid;
   logic signed [NP*DW-1:0]  pe_data;
   logic signed [3*DW-1:0]   pe3;
   logic signed [DW-1:0]     fifo_data;
   logic                     acc_first;
   logic                     approx_en;
   logic                     clr_sticky;
   logic                     out_valid;
   logic signed [DW-1:0]     out;
   logic                     sat;
   logic                     sat_sticky;
   logic                     ov3;
   logic signed [DW-1:0]     o3;
   logic                     s3;
   logic                     ss3_unused;

   psum_add_tree #(.DATA_W(DW), .NUM_PE(NP), .APPROX_BITS(AB)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .pe_data    (pe_data),
      .fifo_data  (fifo_data),
      .acc_first  (acc_first),
      .approx_en  (approx_en),
      .clr_sticky (clr_sticky),
      .out_valid  (out_valid),
      .out        (out),
      .sat        (sat),
      .sat_sticky (sat_sticky)
   );

   psum_add_tree #(.DATA_W(DW), .NUM_PE(3), .APPROX_BITS(AB)) dut3 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .pe_data    (pe3),
      .fifo_data  (fifo_data),
      .acc_first  (acc_first),
      .approx_en  (approx_en),
      .clr_sticky (clr_sticky),
      .out_valid  (ov3),
      .out        (o3),
      .sat        (s3),
      .sat_sticky (ss3_unused)
   );

   typedef struct {
      logic signed [DW-1:0] o;
      logic                 s;
      int                   ec;
   } exp_t;

   exp_t                 q[$];
   int                   errors = 0;
   int                   checks = 0;
   int                   ecnt   = 0;
   int                   n_in   = 0;
   int                   n_out  = 0;
   logic signed [DW-1:0] nxt_o;
   logic                 nxt_s;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: push at the capture edge, pop when a result is produced.
   always @(posedge clk) begin : mon
      logic r, e, iv;
      logic signed [DW-1:0] eo;
      logic es;
      exp_t x;
      r  = rst;
      e  = en;
      iv = in_valid;
      eo = nxt_o;
      es = nxt_s;
      #1;
      if (r) begin
         n_in -= q.size();
         q.delete();
      end else if (e) begin
         if (iv) begin
            q.push_back('{eo, es, ecnt});
            n_in++;
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               x = q.pop_front();
               chk("out", out, x.o);
               chk("sat", sat, x.s);
               chk("latency", ecnt - x.ec + 1, 3);
               n_out++;
            end
         end
         ecnt++;
      end
   end

   task automatic send(input int p0, input int p1, input int p2, input int p3,
                       input int f, input logic first, input logic ax,
                       input int eo, input logic es);
      @(negedge clk);
      in_valid  = 1'b1;
      pe_data   = {DW'(p3), DW'(p2), DW'(p1), DW'(p0)};
      fifo_data = DW'(f);
      acc_first = first;
      approx_en = ax;
      nxt_o     = DW'(eo);
      nxt_s     = es;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   localparam int MX = 16777215;
   localparam int MN = -16777216;

   initial begin
      rst        = 1'b1;
      en         = 1'b1;
      in_valid   = 1'b0;
      pe_data    = '0;
      pe3        = {DW'(9), DW'(-7), DW'(5)};
      fifo_data  = '0;
      acc_first  = 1'b0;
      approx_en  = 1'b0;
      clr_sticky = 1'b0;
      nxt_o      = '0;
      nxt_s      = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_sat", sat, 0);
      chk("rst_sticky", sat_sticky, 0);
      rst = 1'b0;

      send(1, 2, 3, 4, 10, 1'b0, 1'b0, 20, 1'b0);
      idle(3);

      send(5, -7, 9, 0, -1, 1'b0, 1'b0, 6, 1'b0);
      idle(3);
      chk("pe3_valid", ov3, 1);
      chk("pe3_out", o3, 6);
      chk("pe3_sat", s3, 0);

      send(63, 63, 63, 63, 0, 1'b0, 1'b1, 255, 1'b0);
      send(63, 63, 63, 63, 500, 1'b1, 1'b1, 255, 1'b0);
      send(63, 63, 63, 63, 0, 1'b0, 1'b0, 252, 1'b0);
      send(-3, 5, 0, 0, 0, 1'b1, 1'b0, 2, 1'b0);
      idle(4);

      send(MX, MX, MX, MX, 0, 1'b0, 1'b0, MX, 1'b1);
      idle(3);
      chk("sticky_set_max", sat_sticky, 1);
      send(MN, MN, MN, MN, 0, 1'b0, 1'b0, MN, 1'b1);
      send(MX, 0, 0, 0, 1, 1'b0, 1'b0, MX, 1'b1);
      send(MN, 0, 0, 0, -1, 1'b0, 1'b0, MN, 1'b1);
      send(MX, 0, 0, 0, 0, 1'b0, 1'b0, MX, 1'b0);
      idle(4);
      chk("sticky_held", sat_sticky, 1);
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
      chk("sticky_clr", sat_sticky, 0);

      send(MX, MX, 0, 0, 0, 1'b0, 1'b0, MX, 1'b1);
      idle(1);
      @(negedge clk);
      clr_sticky = 1'b1;
      @(negedge clk);
      chk("sticky_set_wins", sat_sticky, 1);
      @(negedge clk);
      chk("sticky_clr_after", sat_sticky, 0);
      clr_sticky = 1'b0;

      send(100, 200, 300, 400, 0, 1'b1, 1'b0, 1000, 1'b0);
      send(-1, -2, -3, -4, 7, 1'b0, 1'b0, -3, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      en       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      en = 1'b1;
      idle(1);
      send(11, 0, 0, 0, 0, 1'b1, 1'b0, 11, 1'b0);
      idle(1);
      send(0, 0, 0, 12, 0, 1'b1, 1'b0, 12, 1'b0);
      idle(4);

      send(1, 1, 1, 1, 0, 1'b0, 1'b0, 4, 1'b0);
      send(2, 2, 2, 2, 0, 1'b0, 1'b0, 8, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_out", out, 0);
      chk("midrst_sat", sat, 0);
      rst = 1'b0;
      send(7, 8, 9, 10, 66, 1'b0, 1'b0, 100, 1'b0);
      idle(4);

      for (int i = 0; i < 6; i++) begin
         int     p[4];
         int     f;
         logic   fr;
         longint s;
         for (int k = 0; k < 4; k++)
            p[k] = int'($urandom_range(0, 33554431)) - 16777216;
         f  = int'($urandom_range(0, 33554431)) - 16777216;
         fr = 1'($urandom_range(0, 1));
         s  = longint'(p[0]) + p[1] + p[2] + p[3] + (fr ? 0 : f);
         if (s > MX)
            send(p[0], p[1], p[2], p[3], f, fr, 1'b0, MX, 1'b1);
         else if (s < MN)
            send(p[0], p[1], p[2], p[3], f, fr, 1'b0, MN, 1'b1);
         else
            send(p[0], p[1], p[2], p[3], f, fr, 1'b0, int'(s), 1'b0);
      end
      idle(6);

      chk("queue_drain", q.size(), 0);
      chk("in_out_count", n_out, n_in);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psum_add_tree.md
PSUM_ADD_TREE -- requirements
Module: psum_add_tree

Interface
Parameters:
REQ-001 DATA_W, 25, signed width of each PE operand, fifo_data and out.
REQ-002 NUM_PE, 4, number of PE operands; legal range 2..16.
REQ-003 APPROX_BITS, 6, low bits handled by the approximate adder; legal range 0..DATA_W-1; 0 means always exact.

Ports:
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 en  in  1  pipeline advance; 0 freezes every pipeline register.
REQ-007 in_valid  in  1  pe_data/fifo_data/acc_first/approx_en valid this cycle.
REQ-008 pe_data  in  NUM_PE*DATA_W  packed signed PE psums, lane i at [i*DATA_W +: DATA_W].
REQ-009 fifo_data  in  DATA_W  signed running psum from the psum FIFO.
REQ-010 acc_first  in  1  1 = first channel; substitute 0 for fifo_data.
REQ-011 approx_en  in  1  1 = approximate low-part addition for this sample.
REQ-012 clr_sticky  in  1  clears sat_sticky.
REQ-013 out_valid  out  1  out is valid.
REQ-014 out  out  DATA_W  signed saturated result.
REQ-015 sat  out  1  out was clamped this sample; qualified by out_valid.
REQ-016 sat_sticky  out  1  sticky OR of all qualified sat pulses.

Function
REQ-017 Tree: LEVELS = clog2(NUM_PE) registered pairwise-adder levels; lanes padded with zero to 2^LEVELS.
REQ-018 Accumulate: one further registered stage adds the tree sum to (acc_first ? 0 : fifo_data) and saturates; fifo_data and acc_first are delayed alongside the sample so they align with it at this stage.
REQ-019 Latency: exactly LEVELS+1 en-high cycles from in_valid to out_valid (3 for NUM_PE=4); throughput 1 sample/cycle.
REQ-020 Width: each level grows 1 bit (sign-extended); accumulate stage width DATA_W+LEVELS+1; no intermediate wrap.
REQ-021 Approx adder (per node and accumulate stage, when approx_en=1 and APPROX_BITS>0): sum[K-1:0]=a[K-1:0]|b[K-1:0]; carry into bit K = a[K-1]&b[K-1]; upper bits exact; K=APPROX_BITS.
REQ-022 approx_en is captured with the sample and travels with it; mode changes take effect per sample, never mid-sample.
REQ-023 Saturation: result > 2^(DATA_W-1)-1 -> max, < -2^(DATA_W-1) -> min, sat=1; else passthrough, sat=0.
REQ-024 en=0: all data, valid and mode registers hold; out, out_valid and sat hold their values.
REQ-025 in_valid=0 with en=1: a bubble propagates; out_valid=0 for that slot; out and sat hold their last values.
REQ-026 sat_sticky sets when out_valid&sat; clr_sticky clears it; a simultaneous set and clear results in set.

Reset
REQ-027 rst=1 at a clock edge clears all valid bits, data registers, out, sat and sat_sticky to 0, regardless of en.
REQ-028 Reset mid-operation discards in-flight samples; the first sample after rst deasserts appears after the full latency.

Structure
REQ-029 Package psum_pkg holds a clog2 constant function and the default DATA_W/APPROX_BITS constants.
REQ-030 One sub-module psum_add_lo (parametrised width and K, with approx_en input) implements REQ-021; it is instantiated for every tree node and for the accumulate stage.
REQ-031 Tree levels are generate-loop based; no hand-unrolled levels.

Verification (DATA_W=25, NUM_PE=4, APPROX_BITS=6)
REQ-032 Exact: pe=1,2,3,4, fifo=10, acc_first=0, approx_en=0 -> out=20 exactly 3 cycles later, sat=0.
REQ-033 Approx: all pe=63, fifo=0, approx_en=1 -> out=255 (exact would be 252); acc_first=1 with fifo=500 -> out=255.
REQ-034 Saturation: all pe=16777215, fifo=0 -> out=16777215, sat=1, sat_sticky=1; all pe=-16777216 -> out=-16777216, sat=1; clr_sticky -> sat_sticky=0.
REQ-035 Stall/bubbles: back-to-back samples with en=0 for 2 cycles mid-flight -> outputs in order, latency 3+2, no loss or duplication.
REQ-036 Reset mid-flight: rst during 2 in-flight samples -> out_valid=0 and out=0 next cycle; a new sample yields the correct result 3 cycles after issue.
REQ-037 NUM_PE=3: pe=5,-7,9, fifo=-1 -> out=6 after 3 cycles, with zero padding of lane 3.
